// File: rtl/aclock_pkg.sv
// Shared types and BCD helpers for the alarm-clock setter.
// Hour/minute increments wrap inside their own field only.
package aclock_pkg;

   typedef enum logic [1:0] {
      IDLE,
      EDIT_H,
      EDIT_M,
      LOAD
   } state_t;

   localparam logic [1:0] HR_T_MAX     = 2'd2;
   localparam logic [3:0] HR_U_MAX_AT2 = 4'd3;
   localparam logic [3:0] MIN_T_MAX    = 4'd5;
   localparam logic [3:0] DIG_MAX      = 4'd9;

   typedef struct packed {
      logic [1:0] t;
      logic [3:0] u;
   } hr_t;

   typedef struct packed {
      logic [3:0] t;
      logic [3:0] u;
   } min_t;

   function automatic hr_t hr_inc(hr_t h);
      hr_t r;
      r = h;
      if (h.t == HR_T_MAX && h.u == HR_U_MAX_AT2) begin
         r = '0;
      end else if (h.u == DIG_MAX) begin
         r.t = h.t + 2'd1;
         r.u = '0;
      end else begin
         r.u = h.u + 4'd1;
      end
      return r;
   endfunction

   function automatic min_t min_inc(min_t m);
      min_t r;
      r = m;
      if (m.u == DIG_MAX) begin
         r.u = '0;
         r.t = (m.t == MIN_T_MAX) ? 4'd0 : m.t + 4'd1;
      end else begin
         r.u = m.u + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/aclock_btn.sv
// Button front end: 2-FF synchronizer, stability debounce,
// one-cycle press pulse on the accepted rising level.
module aclock_btn #(
   parameter int DEB_CYCLES = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic press,
   output logic held
);

   localparam int CW = $clog2(DEB_CYCLES + 1);

   logic          s1;
   logic          s2;
   logic [CW-1:0] cnt;

   // held only follows s2 after it differs for DEB_CYCLES straight cycles
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         cnt   <= '0;
         held  <= 1'b0;
         press <= 1'b0;
      end else begin
         s1    <= btn;
         s2    <= s1;
         press <= 1'b0;
         if (s2 == held) begin
            cnt <= '0;
         end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            cnt   <= '0;
            held  <= s2;
            press <= s2;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/aclock_setter.sv
// Push-button editor producing BCD time values and load strobes
// for the alarm clock core.
module aclock_setter
   import aclock_pkg::*;
#(
   parameter int DEB_CYCLES = 3,
   parameter int REP_CYCLES = 5,
   parameter int LD_CYCLES  = 2,
   parameter int TMO_CYCLES = 300
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_set,
   input  logic       btn_inc,
   output logic [1:0] H_in1,
   output logic [3:0] H_in0,
   output logic [3:0] M_in1,
   output logic [3:0] M_in0,
   output logic       LD_time,
   output logic       LD_alarm,
   output logic       edit_on,
   output logic       edit_fld,
   output logic       edit_alm
);

   localparam int TW = $clog2(TMO_CYCLES + 1);
   localparam int RW = $clog2(REP_CYCLES + 1);
   localparam int LW = $clog2(LD_CYCLES + 1);

   logic mode_p, set_p, inc_p;
   logic mode_h, set_h, inc_h;

   aclock_btn #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
      .clk(clk), .reset(reset), .btn(btn_mode),
      .press(mode_p), .held(mode_h)
   );
   aclock_btn #(.DEB_CYCLES(DEB_CYCLES)) u_set (
      .clk(clk), .reset(reset), .btn(btn_set),
      .press(set_p), .held(set_h)
   );
   aclock_btn #(.DEB_CYCLES(DEB_CYCLES)) u_inc (
      .clk(clk), .reset(reset), .btn(btn_inc),
      .press(inc_p), .held(inc_h)
   );

   state_t        state, state_n;
   logic          alm, alm_n;
   hr_t           hr, hr_n;
   min_t          mn, mn_n;
   logic [TW-1:0] tmo_cnt;
   logic [RW-1:0] rep_cnt;
   logic [LW-1:0] ld_cnt;
   logic          editing, inc_ev, any_ev, tmo_hit;

   assign editing = (state == EDIT_H) || (state == EDIT_M);
   assign inc_ev  = inc_p |
                    (inc_h && rep_cnt == RW'(REP_CYCLES - 1));
   assign any_ev  = mode_p | set_p | inc_ev;
   assign tmo_hit = !any_ev &&
                    tmo_cnt == TW'(TMO_CYCLES - 1);

   always_comb begin
      state_n = state;
      alm_n   = alm;
      hr_n    = hr;
      mn_n    = mn;
      unique case (state)
         IDLE: begin
            if (mode_p) begin
               state_n = EDIT_H;
               alm_n   = 1'b0;
            end else if (set_p) begin
               state_n = EDIT_H;
               alm_n   = 1'b1;
            end
         end
         EDIT_H: begin
            if (mode_p || tmo_hit) state_n = IDLE;
            else if (set_p)        state_n = EDIT_M;
            else if (inc_ev)       hr_n    = hr_inc(hr);
         end
         EDIT_M: begin
            if (mode_p || tmo_hit) state_n = IDLE;
            else if (set_p)        state_n = LOAD;
            else if (inc_ev)       mn_n    = min_inc(mn);
         end
         LOAD: begin
            if (ld_cnt == LW'(LD_CYCLES - 1)) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // a held button means the user is still active, so idle time waits
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         alm      <= 1'b0;
         hr       <= '0;
         mn       <= '0;
         tmo_cnt  <= '0;
         rep_cnt  <= '0;
         ld_cnt   <= '0;
         LD_time  <= 1'b0;
         LD_alarm <= 1'b0;
      end else begin
         state    <= state_n;
         alm      <= alm_n;
         hr       <= hr_n;
         mn       <= mn_n;
         tmo_cnt  <= (!editing || any_ev || mode_h || set_h || inc_h)
                     ? '0 : tmo_cnt + TW'(1);
         rep_cnt  <= (!editing || !inc_h || inc_ev)
                     ? '0 : rep_cnt + RW'(1);
         ld_cnt   <= (state == LOAD) ? ld_cnt + LW'(1) : '0;
         LD_time  <= (state_n == LOAD) && !alm_n;
         LD_alarm <= (state_n == LOAD) && alm_n;
      end
   end

   assign H_in1    = hr.t;
   assign H_in0    = hr.u;
   assign M_in1    = mn.t;
   assign M_in0    = mn.u;
   assign edit_on  = editing;
   assign edit_fld = (state == EDIT_M);
   assign edit_alm = alm;

endmodule

// File: tb/tb_aclock_setter.sv
// Directed bench for aclock_setter: table of button sequences
// followed by hand-written repeat, glitch, abort and reset cases.
module tb_aclock_setter;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_set = 1'b0;
   logic       btn_inc = 1'b0;
   logic [1:0] H_in1;
   logic [3:0] H_in0, M_in1, M_in0;
   logic       LD_time, LD_alarm;
   logic       edit_on, edit_fld, edit_alm;

   int checks = 0;
   int errors = 0;
   int ldt_tot = 0;
   int lda_tot = 0;
   int both_tot = 0;

   aclock_setter dut (
      .clk(clk), .reset(reset),
      .btn_mode(btn_mode), .btn_set(btn_set), .btn_inc(btn_inc),
      .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
      .LD_time(LD_time), .LD_alarm(LD_alarm),
      .edit_on(edit_on), .edit_fld(edit_fld), .edit_alm(edit_alm)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (LD_time) ldt_tot <= ldt_tot + 1;
      if (LD_alarm) lda_tot <= lda_tot + 1;
      if (LD_time && LD_alarm) both_tot <= both_tot + 1;
   end

   typedef struct {
      logic [2:0]  btn;
      int          n;
      logic [15:0] hm;
      logic [2:0]  flg;
      int          ldt;
      int          lda;
   } vec_t;

   localparam logic [2:0] B_RST = 3'b000;
   localparam logic [2:0] B_M   = 3'b001;
   localparam logic [2:0] B_S   = 3'b010;
   localparam logic [2:0] B_I   = 3'b100;

   vec_t vec [23];

   function automatic logic [15:0] hm_now();
      return {2'b00, H_in1, H_in0, M_in1, M_in0};
   endfunction

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic do_press(input logic [2:0] m);
      @(negedge clk);
      btn_mode = m[0];
      btn_set  = m[1];
      btn_inc  = m[2];
      repeat (4) @(negedge clk);
      btn_mode = 1'b0;
      btn_set  = 1'b0;
      btn_inc  = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   function automatic vec_t mk(logic [2:0] b, int n, logic [15:0] hm,
                               logic [2:0] f, int ldt, int lda);
      vec_t v;
      v.btn = b; v.n = n; v.hm = hm; v.flg = f;
      v.ldt = ldt; v.lda = lda;
      return v;
   endfunction

   initial begin
      int t0, a0;
      int nchg, last_i;
      logic [15:0] prev;
      logic [15:0] exp_m [5];
      logic seen;

      // flags are {edit_on, edit_fld, edit_alm}
      vec[0]  = mk(B_RST, 1,  16'h0000, 3'b000, 0, 0);
      vec[1]  = mk(B_M,   1,  16'h0000, 3'b100, 0, 0);
      vec[2]  = mk(B_I,   3,  16'h0300, 3'b100, 0, 0);
      vec[3]  = mk(B_S,   1,  16'h0300, 3'b110, 0, 0);
      vec[4]  = mk(B_I,   2,  16'h0302, 3'b110, 0, 0);
      vec[5]  = mk(B_S,   1,  16'h0302, 3'b000, 2, 0);
      vec[6]  = mk(B_RST, 1,  16'h0000, 3'b000, 0, 0);
      vec[7]  = mk(B_S,   1,  16'h0000, 3'b101, 0, 0);
      vec[8]  = mk(B_I,   10, 16'h1000, 3'b101, 0, 0);
      vec[9]  = mk(B_S,   1,  16'h1000, 3'b111, 0, 0);
      vec[10] = mk(B_S,   1,  16'h1000, 3'b001, 0, 2);
      vec[11] = mk(B_S,   1,  16'h1000, 3'b101, 0, 0);
      vec[12] = mk(B_I,   13, 16'h2300, 3'b101, 0, 0);
      vec[13] = mk(B_S,   1,  16'h2300, 3'b111, 0, 0);
      vec[14] = mk(B_I,   59, 16'h2359, 3'b111, 0, 0);
      vec[15] = mk(B_S,   1,  16'h2359, 3'b001, 0, 2);
      vec[16] = mk(B_M,   1,  16'h2359, 3'b100, 0, 0);
      vec[17] = mk(B_S,   1,  16'h2359, 3'b110, 0, 0);
      vec[18] = mk(B_I,   1,  16'h2300, 3'b110, 0, 0);
      vec[19] = mk(B_M,   1,  16'h2300, 3'b000, 0, 0);
      vec[20] = mk(B_M,   1,  16'h2300, 3'b100, 0, 0);
      vec[21] = mk(B_I,   1,  16'h0000, 3'b100, 0, 0);
      vec[22] = mk(B_M,   1,  16'h0000, 3'b000, 0, 0);

      for (int r = 0; r < 23; r++) begin
         t0 = ldt_tot;
         a0 = lda_tot;
         if (vec[r].btn == B_RST) do_reset();
         else for (int k = 0; k < vec[r].n; k++) do_press(vec[r].btn);
         chk($sformatf("row%0d", r),
             {hm_now(), 5'b0, edit_on, edit_fld, edit_alm,
              4'(ldt_tot - t0), 4'(lda_tot - a0)},
             {vec[r].hm, 5'b0, vec[r].flg,
              4'(vec[r].ldt), 4'(vec[r].lda)});
      end

      // auto-repeat from minute 58
      do_press(B_M);
      do_press(B_S);
      for (int k = 0; k < 58; k++) do_press(B_I);
      chk("rep_start", {16'h0, hm_now()}, 32'h0058);
      exp_m[0] = 16'h0059; exp_m[1] = 16'h0000; exp_m[2] = 16'h0001;
      exp_m[3] = 16'h0002; exp_m[4] = 16'h0003;
      nchg = 0; last_i = 0; prev = hm_now();
      @(negedge clk);
      btn_inc = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 25) btn_inc = 1'b0;
         if (hm_now() != prev) begin
            if (nchg < 5) chk($sformatf("rep_val%0d", nchg),
                              {16'h0, hm_now()}, {16'h0, exp_m[nchg]});
            if (nchg > 0) chk($sformatf("rep_gap%0d", nchg),
                              i - last_i, 5);
            nchg++;
            last_i = i;
            prev = hm_now();
         end
      end
      chk("rep_count", nchg, 5);
      chk("rep_final", {16'h0, hm_now()}, 32'h0003);

      // short glitch on SET while idle
      do_press(B_M);
      chk("abort_idle", {31'h0, edit_on}, 32'h0);
      @(negedge clk);
      btn_set = 1'b1;
      repeat (2) @(negedge clk);
      btn_set = 1'b0;
      repeat (12) @(negedge clk);
      chk("glitch", {30'h0, edit_on, edit_alm}, 32'h0);

      // MODE and INC together abort without incrementing
      do_press(B_M);
      t0 = ldt_tot + lda_tot;
      do_press(B_M | B_I);
      chk("mode_inc", {hm_now(), 15'h0, edit_on},
          {16'h0003, 16'h0});
      chk("mode_inc_ld", ldt_tot + lda_tot - t0, 0);

      // edit timeout
      do_press(B_M);
      do_press(B_S);
      t0 = ldt_tot + lda_tot;
      repeat (280) @(negedge clk);
      chk("tmo_before", {30'h0, edit_on, edit_fld}, 32'h3);
      repeat (30) @(negedge clk);
      chk("tmo_after", {hm_now(), 15'h0, edit_on},
          {16'h0003, 16'h0});
      chk("tmo_ld", ldt_tot + lda_tot - t0, 0);

      // reset while loading
      do_press(B_S);
      do_press(B_S);
      @(negedge clk);
      btn_set = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (LD_alarm) seen = 1'b1;
      end
      chk("ld_seen", {31'h0, seen}, 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("rst_load", {hm_now(), 13'h0, LD_time, LD_alarm, edit_on},
          32'h0);
      btn_set = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("both_strobes", both_tot, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
